// File: rtl/cache_mem_responder.sv
// -----------------------------------------------------------------------------
// cache_mem_responder
// Backing-memory responder for the 2-way write-back cache. Holds a 32 x 3-bit
// main memory, services line fills after a fixed access latency and commits a
// dirty victim (if any) before the fill is read.
//
// Optional build macro: MEM_WB_FORWARD_EN -- when the victim address equals the
// fill address, the fill is forwarded from the victim data and the read phase
// is skipped.
//
// Ports:
//   clock      in   rising-edge clock
//   reset      in   asynchronous active-high reset
//   req_valid  in   miss request present
//   req_ready  out  responder idle and able to accept a request
//   req_wb     in   request carries a dirty victim
//   req_addr   in   fill address
//   wb_addr    in   victim address (valid with req_wb)
//   wb_data    in   victim data    (valid with req_wb)
//   resp_valid out  fill data valid
//   resp_ready in   cache consumes the fill
//   resp_data  out  fill word
//   wb_done    out  one-cycle pulse when the victim is committed
//   busy       out  not idle
// -----------------------------------------------------------------------------
module cache_mem_responder #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 3,
  parameter int unsigned LAT    = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wb,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic              wb_done,
  output logic              busy
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LAT - 1);

  typedef enum logic [1:0] {IDLE, WB, RD, RESP} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic [ADDR_W-1:0] wb_addr_q, wb_addr_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic [DATA_W-1:0] resp_data_q, resp_data_d;
  logic              resp_valid_q, resp_valid_d;
  logic              wb_done_q, wb_done_d;
  logic              req_ready_q, req_ready_d;
  logic              busy_q, busy_d;
  logic              mem_we;
  logic [DATA_W-1:0] mem_q [DEPTH];

  // State register, output registers and memory; reset restores the memory image.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      req_addr_q   <= '0;
      wb_addr_q    <= '0;
      wb_data_q    <= '0;
      resp_data_q  <= '0;
      resp_valid_q <= 1'b0;
      wb_done_q    <= 1'b0;
      req_ready_q  <= 1'b1;
      busy_q       <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= DATA_W'(i);
      end
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      req_addr_q   <= req_addr_d;
      wb_addr_q    <= wb_addr_d;
      wb_data_q    <= wb_data_d;
      resp_data_q  <= resp_data_d;
      resp_valid_q <= resp_valid_d;
      wb_done_q    <= wb_done_d;
      req_ready_q  <= req_ready_d;
      busy_q       <= busy_d;
      if (mem_we) begin
        mem_q[wb_addr_q] <= wb_data_q;
      end
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    req_addr_d   = req_addr_q;
    wb_addr_d    = wb_addr_q;
    wb_data_d    = wb_data_q;
    resp_data_d  = resp_data_q;
    resp_valid_d = resp_valid_q;
    wb_done_d    = 1'b0;
    mem_we       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          req_addr_d = req_addr;
          wb_addr_d  = wb_addr;
          wb_data_d  = wb_data;
          cnt_d      = CNT_LOAD;
          state_d    = req_wb ? WB : RD;
        end
      end
      WB: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          mem_we    = 1'b1;
          wb_done_d = 1'b1;
          cnt_d     = CNT_LOAD;
          state_d   = RD;
`ifdef MEM_WB_FORWARD_EN
          // Victim is the line being filled: answer straight from the victim data.
          if (wb_addr_q == req_addr_q) begin
            resp_data_d  = wb_data_q;
            resp_valid_d = 1'b1;
            state_d      = RESP;
          end
`endif
        end
      end
      RD: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          // Memory already holds any victim committed in WB.
          resp_data_d  = mem_q[req_addr_q];
          resp_valid_d = 1'b1;
          state_d      = RESP;
        end
      end
      RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Status outputs are registered from the next state.
    req_ready_d = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign wb_done    = wb_done_q;
  assign busy       = busy_q;

endmodule

// File: doc/cache_mem_responder.md
Name: cache_mem_responder

Overview:
- Backing-memory responder for the 2-way write-back cache: services line fills on a miss and accepts dirty-victim write-backs.
- Holds the 32-word x 3-bit main memory, addressed by the 5-bit cache address (tag + index).
- A miss with write-back is one request: the victim is committed first, then the fill data is returned.
- Fixed access latency models slow memory; a request/response valid-ready handshake decouples it from the cache.

Parameters:
- ADDR_W, 5, memory address width (tag 3 + index 2).
- DATA_W, 3, word width.
- LAT, 2, clock edges per memory access (write or read); legal range 1..15.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  cache presents a miss request.
- req_ready  out  1  responder can accept a request.
- req_wb  in  1  request carries a dirty victim to write back first.
- req_addr  in  ADDR_W  fill address.
- wb_addr  in  ADDR_W  victim address; meaningful only when req_wb=1.
- wb_data  in  DATA_W  victim data; meaningful only when req_wb=1.
- resp_valid  out  1  fill data valid.
- resp_ready  in  1  cache consumes the fill.
- resp_data  out  DATA_W  fill word.
- wb_done  out  1  one-cycle pulse when the victim is committed to memory.
- busy  out  1  state != IDLE.

Behaviour:
- Reset: state=IDLE, req_ready=1, resp_valid=0, resp_data=0, wb_done=0, busy=0. Counter=0. mem[i] = i[2:0] for i=0..31.
- Reset asserted mid-operation aborts the transaction. No pending write-back is committed, and memory returns to the reset image.
- State machine: IDLE, WB, RD, RESP. All outputs are registered; req_ready=1 only in IDLE.
- IDLE: on req_valid&req_ready, latch req_addr, wb_addr, wb_data and req_wb, and load cnt=LAT-1. Go to WB if req_wb=1, else RD.
- WB: if cnt!=0, decrement. If cnt==0: mem[wb_addr]<=wb_data, wb_done pulses high for exactly one cycle, cnt<=LAT-1, go to RD.
- RD: if cnt!=0, decrement. If cnt==0: resp_data<=mem[req_addr] (post-write-back contents), resp_valid<=1, go to RESP.
- RESP: resp_valid and resp_data are held stable until resp_ready=1. On that edge: resp_valid<=0, go to IDLE. A new request is accepted no earlier than the next edge.
- Latency, counting from accept edge E0:
  - read-only request: resp_valid is first high after edge E0+LAT.
  - with write-back: wb_done is high after edge E0+LAT; resp_valid after edge E0+2*LAT.
- LAT=1: each phase takes a single edge, with no idle cycle.
- req_valid while busy is ignored; inputs are not re-sampled.
- resp_ready while resp_valid=0 is ignored.
- wb_addr==req_addr with req_wb=1: the fill returns wb_data, because the write commits before the read.
- Address arithmetic is unsigned with no wrap beyond 5 bits; all 32 entries are addressable.

Optional Feature:
- Macro MEM_WB_FORWARD_EN.
- Defined: in WB at commit, if the latched wb_addr==req_addr, also load resp_data<=wb_data and resp_valid<=1, and go directly to RESP. The RD phase is skipped, so response latency is LAT. Memory is still written, and wb_done still pulses.
- Undefined: the RD phase always runs, and latency is 2*LAT regardless of address match.

Test Plan (LAT=2):
- Release reset, then req_addr=13 with req_wb=0 accepted at E0 -> resp_valid high after E0+2 with resp_data=5; resp_ready=1 -> resp_valid=0 and req_ready=1 on the next edge.
- req_wb=1, wb_addr=9, wb_data=6, req_addr=2 -> wb_done pulses after E0+2 for one cycle; resp_valid after E0+4 with data=2. A following read of addr 9 returns 6.
- Backpressure: hold resp_ready=0 for 5 cycles while toggling req_valid with req_addr=4 -> resp_valid/resp_data are stable, req_ready=0, and no second transaction starts.
- Assert reset one cycle into WB (wb_addr=3, wb_data=0) -> all outputs return to reset values, wb_done never pulses, and a later read of addr 3 returns 3.
- wb_addr=req_addr=7, wb_data=1 -> resp_data=1. Response is after E0+4 without MEM_WB_FORWARD_EN and after E0+2 with it; a subsequent read of addr 7 returns 1 in both builds.
- LAT=1 build: back-to-back reads of addr 0 and addr 31 with resp_ready held at 1 -> responses 0 and 7. Each resp_valid is high after accept+1 edge, and req_ready is low for exactly 2 cycles per transaction.
